// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory read feeding a 4-entry {pc, instr} FIFO.
// Optional same-cycle bypass of returned data when empty: define FQ_BYPASS_EN.
module fetch_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        flush,
    input  logic        memRdy,
    input  logic [15:0] memData,
    input  logic        deqEn,
    output logic        memReq,
    output logic [15:0] memAddr,
    output logic        pcStall,
    output logic [15:0] instr,
    output logic [15:0] instrPC,
    output logic        instrVld,
    output logic        full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  count;
    logic [1:0]  rptr;
    logic [1:0]  wptr;
    logic [15:0] req_addr;
    logic [15:0] q_pc    [4];
    logic [15:0] q_instr [4];

    logic       issue;
    logic       enq;
    logic       bypass;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] count_nxt;

    // issue is gated by rst_n so no request leaves while the block is held in reset
    assign issue   = rst_n && (state == IDLE) && (count < 3'd4) && !flush;
    assign enq     = (state == WAIT) && memRdy && !flush;
    assign memReq  = issue;
    assign memAddr = pc;
    assign pcStall = !(issue || flush);
    assign full    = (count == 3'd4);

`ifdef FQ_BYPASS_EN
    assign bypass = enq && (count == 3'd0);
`else
    assign bypass = 1'b0;
`endif

    assign instrVld = (count != 3'd0) || bypass;
    assign instr    = bypass ? memData  : q_instr[rptr];
    assign instrPC  = bypass ? req_addr : q_pc[rptr];

    // A bypassed word consumed in the same cycle never touches storage
    assign wr_en = enq && !(bypass && deqEn);
    assign rd_en = deqEn && (count != 3'd0);

    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en)
            count_nxt = count + 3'd1;
        else if (rd_en && !wr_en)
            count_nxt = count - 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
            req_addr <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (issue) begin
                    state    <= WAIT;
                    req_addr <= pc;
                end
                WAIT: begin
                    if (memRdy)
                        state <= IDLE;
                    else if (flush)
                        state <= DROP;
                end
                DROP: if (memRdy) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (wr_en) begin
                q_pc[wptr]    <= req_addr;
                q_instr[wptr] <= memData;
            end

            if (flush) begin
                count <= '0;
                rptr  <= '0;
                wptr  <= '0;
            end else begin
                count <= count_nxt;
                if (wr_en) wptr <= wptr + 2'd1;
                if (rd_en) rptr <= rptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a queue-based reference model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic        flush;
    logic        memRdy;
    logic [15:0] memData;
    logic        deqEn;
    logic        memReq;
    logic [15:0] memAddr;
    logic        pcStall;
    logic [15:0] instr;
    logic [15:0] instrPC;
    logic        instrVld;
    logic        full;

    fetch_queue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .flush    (flush),
        .memRdy   (memRdy),
        .memData  (memData),
        .deqEn    (deqEn),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .pcStall  (pcStall),
        .instr    (instr),
        .instrPC  (instrPC),
        .instrVld (instrVld),
        .full     (full)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int checks    = 0;
    int miscompares = 0;

    // Reference model: queue of {pc, instr}, plus whether a read is in flight and
    // whether its data is doomed by an earlier redirect.
    logic [31:0] mq[$];
    bit          outst;
    bit          discard;
    logic [15:0] m_req_addr;
    bit          e_issue;
    bit          e_bypass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        outst      = 0;
        discard    = 0;
        m_req_addr = '0;
    endtask

    // Drive one cycle's inputs, then at mid-cycle compare all outputs against the model.
    task automatic drive(input bit r, input logic [15:0] p, input bit f,
                         input bit rdy, input logic [15:0] d, input bit de);
        rst_n   = r;
        pc      = p;
        flush   = f;
        memRdy  = rdy;
        memData = d;
        deqEn   = de;
        vectors++;
        if (!r) model_reset();
        #4;
        if (!r) begin
            e_issue  = 0;
            e_bypass = 0;
            chk("rst_memReq", {31'b0, memReq}, 32'd0);
            chk("rst_instrVld", {31'b0, instrVld}, 32'd0);
            chk("rst_full", {31'b0, full}, 32'd0);
            chk("rst_instr", {16'b0, instr}, 32'd0);
            chk("rst_instrPC", {16'b0, instrPC}, 32'd0);
            chk("rst_pcStall", {31'b0, pcStall}, {31'b0, !f});
            chk("rst_memAddr", {16'b0, memAddr}, {16'b0, p});
        end else begin
            e_issue = !outst && (mq.size() < 4) && !f;
`ifdef FQ_BYPASS_EN
            e_bypass = outst && !discard && rdy && !f && (mq.size() == 0);
`else
            e_bypass = 0;
`endif
            chk("memReq", {31'b0, memReq}, {31'b0, e_issue});
            chk("memAddr", {16'b0, memAddr}, {16'b0, p});
            chk("pcStall", {31'b0, pcStall}, {31'b0, !(e_issue || f)});
            chk("full", {31'b0, full}, {31'b0, mq.size() == 4});
            chk("instrVld", {31'b0, instrVld}, {31'b0, (mq.size() > 0) || e_bypass});
            if (mq.size() > 0) begin
                chk("instrPC", {16'b0, instrPC}, {16'b0, mq[0][31:16]});
                chk("instr", {16'b0, instr}, {16'b0, mq[0][15:0]});
            end else if (e_bypass) begin
                chk("byp_instrPC", {16'b0, instrPC}, {16'b0, m_req_addr});
                chk("byp_instr", {16'b0, instr}, {16'b0, d});
            end
        end
    endtask

    // Clock edge: advance the model with the inputs that were held across it.
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                mq.delete();
                if (outst && !memRdy) discard = 1;
                else if (outst && memRdy) begin
                    outst   = 0;
                    discard = 0;
                end
            end else begin
                if (deqEn && mq.size() > 0) void'(mq.pop_front());
                if (outst && memRdy) begin
                    if (!discard && !(e_bypass && deqEn))
                        mq.push_back({m_req_addr, memData});
                    outst   = 0;
                    discard = 0;
                end
                if (e_issue) begin
                    outst      = 1;
                    discard    = 0;
                    m_req_addr = pc;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_n = 0; pc = '0; flush = 0; memRdy = 0; memData = '0; deqEn = 0;
        model_reset();
        @(posedge clk); #1;

        drive(0, 16'h0010, 0, 0, 16'h0000, 0); advance();

        // Single fetch with 1-cycle memory
        drive(1, 16'h0010, 0, 0, 16'h0000, 0);
        chk("lit_issue_req", {31'b0, memReq}, 32'd1);
        chk("lit_issue_addr", {16'b0, memAddr}, 32'h0010);
        advance();
        drive(1, 16'h0012, 0, 1, 16'hABCD, 0);
        chk("lit_wait_noreq", {31'b0, memReq}, 32'd0);
        chk("lit_wait_stall", {31'b0, pcStall}, 32'd1);
`ifdef FQ_BYPASS_EN
        chk("lit_byp_vld", {31'b0, instrVld}, 32'd1);
`else
        chk("lit_nobyp_vld", {31'b0, instrVld}, 32'd0);
`endif
        advance();
        drive(1, 16'h0012, 0, 0, 16'h0000, 0);
        chk("lit_head_vld", {31'b0, instrVld}, 32'd1);
        chk("lit_head_pc", {16'b0, instrPC}, 32'h0010);
        chk("lit_head_instr", {16'b0, instr}, 32'h0000ABCD);
        advance();

        // Fill to four entries
        for (int k = 1; k < 4; k++) begin
            drive(1, 16'h0014, 0, 1, 16'(16'h1000 + k), 0); advance();
            if (k < 3) begin
                drive(1, 16'(16'h0012 + 2 * k), 0, 0, 16'h0000, 0); advance();
            end
        end
        drive(1, 16'h0030, 0, 0, 16'h0000, 0);
        chk("lit_full", {31'b0, full}, 32'd1);
        chk("lit_full_noreq", {31'b0, memReq}, 32'd0);
        chk("lit_full_stall", {31'b0, pcStall}, 32'd1);
        advance();
        drive(1, 16'h0030, 0, 0, 16'h0000, 1); advance();
        drive(1, 16'h0020, 0, 0, 16'h0000, 0);
        chk("lit_unfull", {31'b0, full}, 32'd0);
        chk("lit_reissue", {31'b0, memReq}, 32'd1);
        advance();

        // Redirect while waiting; late data is dropped
        drive(1, 16'h0100, 1, 0, 16'h0000, 0);
        chk("lit_flush_stall", {31'b0, pcStall}, 32'd0);
        advance();
        drive(1, 16'h0100, 0, 0, 16'h0000, 0);
        chk("lit_drop_empty", {31'b0, instrVld}, 32'd0);
        chk("lit_drop_noreq", {31'b0, memReq}, 32'd0);
        advance();
        drive(1, 16'h0100, 0, 0, 16'h0000, 0); advance();
        drive(1, 16'h0100, 0, 1, 16'hDEAD, 0);
        chk("lit_drop_rdy_vld", {31'b0, instrVld}, 32'd0);
        advance();
        drive(1, 16'h0100, 0, 0, 16'h0000, 0);
        chk("lit_newpc_req", {31'b0, memReq}, 32'd1);
        chk("lit_newpc_addr", {16'b0, memAddr}, 32'h0100);
        chk("lit_drop_count", {31'b0, instrVld}, 32'd0);
        advance();

        // Reset in WAIT abandons the request
        drive(0, 16'h0100, 0, 0, 16'h0000, 0); advance();
        drive(1, 16'h0200, 0, 1, 16'hBEEF, 0);
        chk("lit_postrst_req", {31'b0, memReq}, 32'd1);
        chk("lit_postrst_addr", {16'b0, memAddr}, 32'h0200);
        chk("lit_postrst_vld", {31'b0, instrVld}, 32'd0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 199) != 0),
                  16'($urandom),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 1) == 1),
                  16'($urandom),
                  ($urandom_range(0, 2) == 0));
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
